// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: operation codes, opcode/funct
// encodings and the instruction-to-operation decode function.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] CTRL_ADD  = 6'd0;
    localparam logic [5:0] CTRL_ADDU = 6'd1;
    localparam logic [5:0] CTRL_SUB  = 6'd2;
    localparam logic [5:0] CTRL_SUBU = 6'd3;
    localparam logic [5:0] CTRL_AND  = 6'd4;
    localparam logic [5:0] CTRL_OR   = 6'd5;
    localparam logic [5:0] CTRL_XOR  = 6'd6;
    localparam logic [5:0] CTRL_NOR  = 6'd7;
    localparam logic [5:0] CTRL_SLT  = 6'd8;
    localparam logic [5:0] CTRL_SLTU = 6'd9;
    localparam logic [5:0] CTRL_SLL  = 6'd10;
    localparam logic [5:0] CTRL_SRL  = 6'd11;
    localparam logic [5:0] CTRL_SRA  = 6'd12;
    localparam logic [5:0] CTRL_SLLV = 6'd13;
    localparam logic [5:0] CTRL_SRLV = 6'd14;
    localparam logic [5:0] CTRL_SRAV = 6'd15;
    localparam logic [5:0] CTRL_LUI  = 6'd16;
    localparam logic [5:0] CTRL_EQ   = 6'd17;
    localparam logic [5:0] CTRL_NE   = 6'd18;
    localparam logic [5:0] CTRL_LEZ  = 6'd19;
    localparam logic [5:0] CTRL_GTZ  = 6'd20;
    localparam logic [5:0] CTRL_LTZ  = 6'd21;
    localparam logic [5:0] CTRL_GEZ  = 6'd22;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL    = 6'b000000;
    localparam logic [5:0] FN_SRL    = 6'b000010;
    localparam logic [5:0] FN_SRA    = 6'b000011;
    localparam logic [5:0] FN_SLLV   = 6'b000100;
    localparam logic [5:0] FN_SRLV   = 6'b000110;
    localparam logic [5:0] FN_SRAV   = 6'b000111;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUB    = 6'b100010;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;
    localparam logic [5:0] FN_XOR    = 6'b100110;
    localparam logic [5:0] FN_NOR    = 6'b100111;
    localparam logic [5:0] FN_SLT    = 6'b101010;
    localparam logic [5:0] FN_SLTU   = 6'b101011;
    localparam logic [5:0] FN_BLTZ   = 6'b110100;
    localparam logic [5:0] FN_BGEZ   = 6'b110101;

    // Anything not recognised (jumps included) falls back to ADD so the
    // datapath always produces a defined value.
    function automatic logic [5:0] decode(input logic [5:0] opcode, input logic [5:0] funct);
        logic [5:0] ctrl;
        ctrl = CTRL_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctrl = CTRL_ADD;
                    FN_ADDU: ctrl = CTRL_ADDU;
                    FN_SUB:  ctrl = CTRL_SUB;
                    FN_SUBU: ctrl = CTRL_SUBU;
                    FN_AND:  ctrl = CTRL_AND;
                    FN_OR:   ctrl = CTRL_OR;
                    FN_XOR:  ctrl = CTRL_XOR;
                    FN_NOR:  ctrl = CTRL_NOR;
                    FN_SLT:  ctrl = CTRL_SLT;
                    FN_SLTU: ctrl = CTRL_SLTU;
                    FN_SLL:  ctrl = CTRL_SLL;
                    FN_SRL:  ctrl = CTRL_SRL;
                    FN_SRA:  ctrl = CTRL_SRA;
                    FN_SLLV: ctrl = CTRL_SLLV;
                    FN_SRLV: ctrl = CTRL_SRLV;
                    FN_SRAV: ctrl = CTRL_SRAV;
                    FN_JR:   ctrl = CTRL_ADD;
                    default: ctrl = CTRL_ADD;
                endcase
            end
            OP_REGIMM: begin
                case (funct)
                    FN_BLTZ: ctrl = CTRL_LTZ;
                    FN_BGEZ: ctrl = CTRL_GEZ;
                    default: ctrl = CTRL_ADD;
                endcase
            end
            OP_ADDI:  ctrl = CTRL_ADD;
            OP_ADDIU: ctrl = CTRL_ADDU;
            OP_ANDI:  ctrl = CTRL_AND;
            OP_ORI:   ctrl = CTRL_OR;
            OP_XORI:  ctrl = CTRL_XOR;
            OP_SLTI:  ctrl = CTRL_SLT;
            OP_SLTIU: ctrl = CTRL_SLTU;
            OP_LUI:   ctrl = CTRL_LUI;
            OP_LB, OP_LW, OP_SB, OP_SW: ctrl = CTRL_ADD;
            OP_BEQ:   ctrl = CTRL_EQ;
            OP_BNE:   ctrl = CTRL_NE;
            OP_BLEZ:  ctrl = CTRL_LEZ;
            OP_BGTZ:  ctrl = CTRL_GTZ;
            default:  ctrl = CTRL_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result bundle between the decode stage and the execute unit.
interface alu_exec_unit_if;
    import alu_pkg::*;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [5:0]       alu_ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic [WIDTH-1:0] add_sum;

    modport master (
        output opcode, funct, shamt, a, b, add_a, add_b,
        input  alu_ctrl, result, zero, overflow, add_sum
    );

    modport slave (
        input  opcode, funct, shamt, a, b, add_a, add_b,
        output alu_ctrl, result, zero, overflow, add_sum
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: computes result, zero/branch flag and signed overflow
// for one decoded operation.
module alu_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       shamt_i,
    input  logic [5:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    // Operation select; only signed ADD/SUB report overflow.
    always_comb begin
        result_o   = '0;
        overflow_o = 1'b0;
        case (ctrl_i)
            CTRL_ADD: begin
                result_o   = sum;
                overflow_o = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
            end
            CTRL_ADDU: result_o = sum;
            CTRL_SUB: begin
                result_o   = diff;
                overflow_o = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
            end
            CTRL_SUBU: result_o = diff;
            CTRL_AND:  result_o = a_i & b_i;
            CTRL_OR:   result_o = a_i | b_i;
            CTRL_XOR:  result_o = a_i ^ b_i;
            CTRL_NOR:  result_o = ~(a_i | b_i);
            CTRL_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            CTRL_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            CTRL_SLL:  result_o = b_i << shamt_i;
            CTRL_SRL:  result_o = b_i >> shamt_i;
            CTRL_SRA:  result_o = $signed(b_i) >>> shamt_i;
            CTRL_SLLV: result_o = b_i << a_i[4:0];
            CTRL_SRLV: result_o = b_i >> a_i[4:0];
            CTRL_SRAV: result_o = $signed(b_i) >>> a_i[4:0];
            CTRL_LUI:  result_o = {b_i[15:0], 16'h0000};
            CTRL_EQ, CTRL_NE: result_o = diff;
            CTRL_LEZ, CTRL_GTZ, CTRL_LTZ, CTRL_GEZ: result_o = a_i;
            default:   result_o = sum;
        endcase
    end

    // Branch ops turn zero into the taken condition; everything else flags a zero result.
    always_comb begin
        zero_o = (result_o == '0);
        case (ctrl_i)
            CTRL_EQ:  zero_o = (a_i == b_i);
            CTRL_NE:  zero_o = (a_i != b_i);
            CTRL_LEZ: zero_o = ($signed(a_i) <= 0);
            CTRL_GTZ: zero_o = ($signed(a_i) > 0);
            CTRL_LTZ: zero_o = a_i[MSB];
            CTRL_GEZ: zero_o = ~a_i[MSB];
            default:  zero_o = (result_o == '0);
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage top: decodes the instruction fields, runs the ALU and the
// independent PC/branch adder, and registers every output.
module alu_exec_unit
    import alu_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    alu_exec_unit_if.slave   bus
);
    logic [5:0]       ctrl_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             overflow_d;
    logic [WIDTH-1:0] sum_d;

    logic [5:0]       ctrl_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;
    logic [WIDTH-1:0] sum_q;

    assign ctrl_d = decode(bus.opcode, bus.funct);
    assign sum_d  = bus.add_a + bus.add_b;

    alu_core u_core (
        .a_i        (bus.a),
        .b_i        (bus.b),
        .shamt_i    (bus.shamt),
        .ctrl_i     (ctrl_d),
        .result_o   (result_d),
        .zero_o     (zero_d),
        .overflow_o (overflow_d)
    );

    // Output register stage; asynchronous reset clears every output at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ctrl_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            sum_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            sum_q      <= sum_d;
        end
    end

    assign bus.alu_ctrl = ctrl_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
    assign bus.add_sum  = sum_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for the execute unit.
module tb_alu_exec_unit;

    typedef struct {
        string       name;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] addA;
        logic [31:0] addB;
        logic [5:0]  expCtrl;
        logic [31:0] expResult;
        logic        expZero;
        logic        expOvf;
        logic [31:0] expSum;
    } vecT;

    logic Clk;
    logic Reset;
    int   totalChecks;
    int   badChecks;
    vecT  vecs[$];

    alu_exec_unit_if busIf ();

    alu_exec_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (busIf)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic addVec(input string name, input logic [5:0] opcode, input logic [5:0] funct,
                          input logic [4:0] shamt, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] addA, input logic [31:0] addB, input logic [5:0] expCtrl,
                          input logic [31:0] expResult, input logic expZero, input logic expOvf,
                          input logic [31:0] expSum);
        vecT v;
        v.name = name; v.opcode = opcode; v.funct = funct; v.shamt = shamt;
        v.a = a; v.b = b; v.addA = addA; v.addB = addB;
        v.expCtrl = expCtrl; v.expResult = expResult; v.expZero = expZero;
        v.expOvf = expOvf; v.expSum = expSum;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vecT v);
        busIf.opcode = v.opcode;
        busIf.funct  = v.funct;
        busIf.shamt  = v.shamt;
        busIf.a      = v.a;
        busIf.b      = v.b;
        busIf.add_a  = v.addA;
        busIf.add_b  = v.addB;
    endtask

    task automatic checkAll(input string name, input logic [5:0] ctrl, input logic [31:0] res,
                            input logic zero, input logic ovf, input logic [31:0] sum);
        checkOutput({name, ".ctrl"}, {26'd0, busIf.alu_ctrl}, {26'd0, ctrl});
        checkOutput({name, ".result"}, busIf.result, res);
        checkOutput({name, ".zero"}, {31'd0, busIf.zero}, {31'd0, zero});
        checkOutput({name, ".ovf"}, {31'd0, busIf.overflow}, {31'd0, ovf});
        checkOutput({name, ".sum"}, busIf.add_sum, sum);
    endtask

    // Main directed sequence: reset, vector table, mid-operation reset.
    initial begin
        logic [31:0] prevResult;
        logic [31:0] prevSum;
        totalChecks = 0;
        badChecks   = 0;

        addVec("add",    6'h00, 6'h20, 5'd0, 32'd7,          32'd5,          32'h400,  32'd4,  6'd0,  32'd12,         1'b0, 1'b0, 32'h404);
        addVec("sub",    6'h00, 6'h22, 5'd0, 32'd5,          32'd5,          32'h404,  32'd4,  6'd2,  32'd0,          1'b1, 1'b0, 32'h408);
        addVec("addOvf", 6'h00, 6'h20, 5'd0, 32'h7FFFFFFF,   32'd1,          32'h1000, 32'h20, 6'd0,  32'h80000000,   1'b0, 1'b1, 32'h1020);
        addVec("addu",   6'h00, 6'h21, 5'd0, 32'h7FFFFFFF,   32'd1,          32'h1000, 32'h24, 6'd1,  32'h80000000,   1'b0, 1'b0, 32'h1024);
        addVec("subOvf", 6'h00, 6'h22, 5'd0, 32'h80000000,   32'd1,          32'h10,   32'h10, 6'd2,  32'h7FFFFFFF,   1'b0, 1'b1, 32'h20);
        addVec("slt",    6'h00, 6'h2A, 5'd0, 32'hFFFFFFFF,   32'd1,          32'd0,    32'd1,  6'd8,  32'd1,          1'b0, 1'b0, 32'd1);
        addVec("sltu",   6'h00, 6'h2B, 5'd0, 32'hFFFFFFFF,   32'd1,          32'd0,    32'd2,  6'd9,  32'd0,          1'b1, 1'b0, 32'd2);
        addVec("sra",    6'h00, 6'h03, 5'd4, 32'd0,          32'h80000000,   32'd3,    32'd3,  6'd12, 32'hF8000000,   1'b0, 1'b0, 32'd6);
        addVec("sll0",   6'h00, 6'h00, 5'd0, 32'd0,          32'hA5A5A5A5,   32'd5,    32'd5,  6'd10, 32'hA5A5A5A5,   1'b0, 1'b0, 32'd10);
        addVec("srlv",   6'h00, 6'h06, 5'd0, 32'd4,          32'h000000F0,   32'd7,    32'd7,  6'd14, 32'h0000000F,   1'b0, 1'b0, 32'd14);
        addVec("nor",    6'h00, 6'h27, 5'd0, 32'd0,          32'd0,          32'd8,    32'd8,  6'd7,  32'hFFFFFFFF,   1'b0, 1'b0, 32'd16);
        addVec("lui",    6'h0F, 6'h34, 5'd0, 32'd0,          32'h00001234,   32'd9,    32'd9,  6'd16, 32'h12340000,   1'b0, 1'b0, 32'd18);
        addVec("lw",     6'h23, 6'h04, 5'd0, 32'd100,        32'd4,          32'd11,   32'd11, 6'd0,  32'd104,        1'b0, 1'b0, 32'd22);
        addVec("beq",    6'h04, 6'h00, 5'd0, 32'd9,          32'd9,          32'h100,  32'h40, 6'd17, 32'd0,          1'b1, 1'b0, 32'h140);
        addVec("bne",    6'h05, 6'h00, 5'd0, 32'd9,          32'd9,          32'h100,  32'h44, 6'd18, 32'd0,          1'b0, 1'b0, 32'h144);
        addVec("blez0",  6'h06, 6'h00, 5'd0, 32'd0,          32'd0,          32'h200,  32'd4,  6'd19, 32'd0,          1'b1, 1'b0, 32'h204);
        addVec("bgtz0",  6'h07, 6'h00, 5'd0, 32'd0,          32'd0,          32'h204,  32'd4,  6'd20, 32'd0,          1'b0, 1'b0, 32'h208);
        addVec("bgez0",  6'h01, 6'h35, 5'd0, 32'd0,          32'd0,          32'h208,  32'd4,  6'd22, 32'd0,          1'b1, 1'b0, 32'h20C);
        addVec("bltz0",  6'h01, 6'h34, 5'd0, 32'd0,          32'd0,          32'h20C,  32'd4,  6'd21, 32'd0,          1'b0, 1'b0, 32'h210);
        addVec("jalWrap",6'h03, 6'h00, 5'd0, 32'd0,          32'd0,          32'hFFFFFFFC, 32'd4, 6'd0, 32'd0,         1'b1, 1'b0, 32'd0);

        Reset = 1'b1;
        busIf.opcode = '0; busIf.funct = '0; busIf.shamt = '0;
        busIf.a = '0; busIf.b = '0; busIf.add_a = '0; busIf.add_b = '0;
        #2;
        checkAll("reset", 6'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        prevResult = 32'd0;
        prevSum    = 32'd0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, ".holdResult"}, busIf.result, prevResult);
            checkOutput({vecs[i].name, ".holdSum"}, busIf.add_sum, prevSum);
            @(posedge Clk); #1;
            checkAll(vecs[i].name, vecs[i].expCtrl, vecs[i].expResult, vecs[i].expZero,
                     vecs[i].expOvf, vecs[i].expSum);
            prevResult = vecs[i].expResult;
            prevSum    = vecs[i].expSum;
        end

        applyStimulus(vecs[0]);
        @(posedge Clk); #1;
        checkAll("preRst", 6'd0, 32'd12, 1'b0, 1'b0, 32'h404);
        #2;
        Reset = 1'b1;
        #1;
        checkAll("midRst", 6'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(posedge Clk); #1;
        checkAll("heldRst", 6'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        checkAll("resume", 6'd0, 32'd12, 1'b0, 1'b0, 32'h404);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
